// File: rtl/mod_mem_writer.sv
// Write-side front end of the modulation sample memory: buffers 16-bit bus words in a
// small FIFO and unpacks each into two consecutive 8-bit BRAM writes.
module mod_mem_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUS_EN,
    input  logic        BUS_WE,
    input  logic [13:0] BUS_ADDR,
    input  logic [15:0] BUS_DATA,
    input  logic        SEGMENT,
    input  logic        CLR_OVERFLOW,
    output logic        MEM_WE,
    output logic        MEM_SEGMENT,
    output logic [14:0] MEM_ADDR,
    output logic [7:0]  MEM_DATA,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic        seg;
        logic [13:0] addr;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    entry_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              overflow_q;
    state_t            state_q;
    logic              mem_we_q, mem_seg_q, busy_q;
    logic [14:0]       mem_addr_q;
    logic [7:0]        mem_data_q, hi_q;

    logic   bus_write, empty, full, push, drop, pop, busy_d;
    entry_t head;

    assign bus_write = BUS_EN & BUS_WE;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign push      = bus_write & ~full;
    assign drop      = bus_write & full;
    assign pop       = ~empty && (state_q == IDLE || state_q == HI);
    assign head      = fifo_mem[rd_ptr_q[IDX_W-1:0]];

    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    // Busy next cycle if anything stays queued or the FSM will be in LO/HI.
    assign busy_d    = (wr_ptr_d != rd_ptr_d) || pop || (state_q == LO);

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= '{seg: SEGMENT, addr: BUS_ADDR, data: BUS_DATA};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (CLR_OVERFLOW) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_we_q   <= 1'b0;
            mem_seg_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            hi_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            mem_we_q <= 1'b0;
            case (state_q)
                LO: begin
                    state_q       <= HI;
                    mem_we_q      <= 1'b1;
                    mem_addr_q[0] <= 1'b1;
                    mem_data_q    <= hi_q;
                end
                IDLE, HI: begin
                    if (pop) begin
                        state_q    <= LO;
                        mem_we_q   <= 1'b1;
                        mem_seg_q  <= head.seg;
                        mem_addr_q <= {head.addr, 1'b0};
                        mem_data_q <= head.data[7:0];
                        hi_q       <= head.data[15:8];
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MEM_WE      = mem_we_q;
    assign MEM_SEGMENT = mem_seg_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_DATA    = mem_data_q;
    assign BUSY        = busy_q;
    assign OVERFLOW    = overflow_q;

endmodule

// File: tb/tb_mod_mem_writer.sv
// Scoreboard bench for mod_mem_writer: expected byte writes are queued as words are
// driven and compared against the observed BRAM write stream.
module tb_mod_mem_writer;

    logic        CLK = 1'b0;
    logic        RST, BUS_EN, BUS_WE, SEGMENT, CLR_OVERFLOW;
    logic [13:0] BUS_ADDR;
    logic [15:0] BUS_DATA;
    logic        MEM_WE, MEM_SEGMENT, BUSY, OVERFLOW;
    logic [14:0] MEM_ADDR;
    logic [7:0]  MEM_DATA;

    typedef struct {
        logic        seg;
        logic [14:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] bram [0:1][0:32767];

    mod_mem_writer #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA), .SEGMENT(SEGMENT), .CLR_OVERFLOW(CLR_OVERFLOW),
        .MEM_WE(MEM_WE), .MEM_SEGMENT(MEM_SEGMENT), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_WE === 1'b1) bram[MEM_SEGMENT][MEM_ADDR] <= MEM_DATA;
    end

    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) obs_q.push_back('{MEM_SEGMENT, MEM_ADDR, MEM_DATA, cyc});
    end

    task automatic idle_bus();
        BUS_EN = 1'b0; BUS_WE = 1'b0; SEGMENT = 1'b0;
        BUS_ADDR = '0; BUS_DATA = '0; CLR_OVERFLOW = 1'b0;
    endtask

    task automatic push_exp(input logic seg, input logic [13:0] addr, input logic [15:0] data);
        exp_q.push_back('{seg, {addr, 1'b0}, data[7:0], 0});
        exp_q.push_back('{seg, {addr, 1'b1}, data[15:8], 0});
    endtask

    // Presents one word for one edge; the caller states whether it should be kept.
    task automatic drive_word(input logic seg, input logic [13:0] addr,
                              input logic [15:0] data, input bit kept);
        BUS_EN = 1'b1; BUS_WE = 1'b1; SEGMENT = seg; BUS_ADDR = addr; BUS_DATA = data;
        if (kept) push_exp(seg, addr, data);
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL %s_timeout: BUSY=%b after 200 cycles, required 0", name, BUSY);
        end
        repeat (2) @(negedge CLK);
    endtask

    task automatic compare_sb(input string name);
        wr_t e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                failures++;
                $display("FAIL %s_missing: no write, required seg=%0d idx=0x%0h data=0x%02h",
                         name, e.seg, e.addr, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.seg !== e.seg || o.addr !== e.addr || o.data !== e.data) begin
                    failures++;
                    $display("FAIL %s_write: got seg=%0d idx=0x%0h data=0x%02h, required seg=%0d idx=0x%0h data=0x%02h",
                             name, o.seg, o.addr, o.data, e.seg, e.addr, e.data);
                end
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s_extra: unexpected write seg=%0d idx=0x%0h data=0x%02h, required none",
                     name, o.seg, o.addr, o.data);
        end
    endtask

    task automatic test_reset();
        idle_bus();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({MEM_WE, MEM_SEGMENT, MEM_ADDR, MEM_DATA} !== 25'd0) begin
            failures++;
            $display("FAIL reset_mem: got we=%b seg=%b idx=0x%0h data=0x%0h, required all 0",
                     MEM_WE, MEM_SEGMENT, MEM_ADDR, MEM_DATA);
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if ({BUSY, OVERFLOW} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags: got busy=%b overflow=%b, required 0 0", BUSY, OVERFLOW);
        end
        obs_q.delete();
    endtask

    task automatic test_single_word();
        int t, n;
        drive_word(1'b0, 14'h0005, 16'hBEEF, 1'b1);
        idle_bus();
        t = cyc;
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL single_busy_len: BUSY high %0d cycles, required 3", n);
        end
        wait_idle("single");
        checks++;
        if (obs_q.size() < 2 || obs_q[0].cyc != t + 1 || obs_q[1].cyc != t + 2) begin
            failures++;
            $display("FAIL single_latency: %0d writes, first at edge offset %0d, required 2 writes at offsets 1,2",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].cyc - t : -1);
        end
        compare_sb("single");
        checks++;
        if ({MEM_WE, MEM_ADDR, MEM_DATA} !== {1'b0, 15'd11, 8'hBE}) begin
            failures++;
            $display("FAIL single_hold: got we=%b idx=%0d data=0x%02h, required 0 11 0xbe",
                     MEM_WE, MEM_ADDR, MEM_DATA);
        end
    endtask

    task automatic test_back_to_back();
        bit gap = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_word(1'b0, 14'(i), {8'(8'h80 + 2 * i + 1), 8'(8'h80 + 2 * i)}, 1'b1);
        end
        idle_bus();
        wait_idle("b2b");
        for (int i = 1; i < obs_q.size(); i++) begin
            if (obs_q[i].cyc != obs_q[0].cyc + i) gap = 1'b1;
        end
        checks++;
        if (obs_q.size() != 8 || gap) begin
            failures++;
            $display("FAIL b2b_stream: %0d writes, bubble=%b, required 8 writes no bubble",
                     obs_q.size(), gap);
        end
        checks++;
        if (OVERFLOW !== 1'b0) begin
            failures++;
            $display("FAIL b2b_overflow: got %b, required 0", OVERFLOW);
        end
        compare_sb("b2b");
    endtask

    // With depth 4 and a 2-cycle drain, words 0..6 fit; word 7 meets a full FIFO.
    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            drive_word(1'b1, 14'(16 + i), {8'(8'h40 + i), 8'(8'h20 + i)}, i != 7);
        end
        idle_bus();
        wait_idle("ovf");
        checks++;
        if (OVERFLOW !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got %b, required 1", OVERFLOW);
        end
        compare_sb("ovf");
        CLR_OVERFLOW = 1'b1;
        @(negedge CLK);
        CLR_OVERFLOW = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear: got %b, required 0", OVERFLOW);
        end
    endtask

    task automatic test_segments();
        logic        segs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [13:0] addrs [4] = '{14'h1234, 14'h1234, 14'h3FFF, 14'h3FFF};
        logic [15:0] datas [4] = '{16'hA1B2, 16'hC3D4, 16'h5566, 16'h7788};
        logic [7:0]  got;
        for (int i = 0; i < 4; i++) drive_word(segs[i], addrs[i], datas[i], 1'b1);
        idle_bus();
        wait_idle("seg");
        compare_sb("seg");
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 2; b++) begin
                got = bram[segs[i]][{addrs[i], b[0]}];
                checks++;
                if (got !== (b == 0 ? datas[i][7:0] : datas[i][15:8])) begin
                    failures++;
                    $display("FAIL seg_readback: seg %0d idx 0x%0h got 0x%02h, required 0x%02h",
                             segs[i], {addrs[i], b[0]}, got,
                             (b == 0 ? datas[i][7:0] : datas[i][15:8]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        drive_word(1'b0, 14'h0020, 16'h1111, 1'b0);
        drive_word(1'b0, 14'h0021, 16'h2222, 1'b0);
        exp_q.push_back('{1'b0, 15'h0040, 8'h11, 0});
        RST = 1'b1;
        drive_word(1'b0, 14'h0022, 16'h3333, 1'b0);
        RST = 1'b0;
        idle_bus();
        checks++;
        if ({BUSY, OVERFLOW} !== 2'b00) begin
            failures++;
            $display("FAIL rst_mid_flags: got busy=%b overflow=%b, required 0 0", BUSY, OVERFLOW);
        end
        repeat (10) @(negedge CLK);
        compare_sb("rst_mid");
        drive_word(1'b1, 14'h0030, 16'hABCD, 1'b1);
        idle_bus();
        wait_idle("rst_after");
        compare_sb("rst_after");
    endtask

    task automatic test_we_low();
        int busy_cycles = 0;
        BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 14'h0077; BUS_DATA = 16'h5A5A;
        repeat (10) begin
            @(negedge CLK);
            if (BUSY !== 1'b0) busy_cycles++;
        end
        idle_bus();
        repeat (3) @(negedge CLK);
        checks++;
        if (busy_cycles != 0) begin
            failures++;
            $display("FAIL we_low_busy: BUSY high %0d cycles, required 0", busy_cycles);
        end
        compare_sb("we_low");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_segments();
        test_reset_mid_drain();
        test_we_low();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
